// File: rtl/palette_bank.sv
// rtl/palette_bank.sv - multi-bank colour lookup RAM with chroma-key detect and frame-stepped fade engine
module palette_bank #(
   parameter int                  NUM_BANKS       = 2,
   parameter int                  IDX_W           = 7,
   parameter int                  CH_W            = 8,
   parameter logic [3*CH_W-1:0]   KEY_COLOR       = 'h0080ff,
   parameter int                  FRAMES_PER_STEP = 2
) (
   input  logic                                  Clk,
   input  logic                                  Reset_n,
   input  logic                                  wr_en,
   input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] wr_bank,
   input  logic [IDX_W-1:0]                      wr_idx,
   input  logic [3*CH_W-1:0]                     wr_data,
   input  logic                                  rd_valid,
   input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] rd_bank,
   input  logic [IDX_W-1:0]                      rd_idx,
   output logic                                  out_valid,
   output logic [3*CH_W-1:0]                     out_color,
   output logic                                  out_key,
   input  logic                                  frame_tick,
   input  logic                                  fade_start,
   input  logic                                  fade_dir,
   output logic                                  fade_busy,
   output logic                                  fade_done,
   output logic [4:0]                            fade_level
);

   localparam int COL_W = 3 * CH_W;
   localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);

   typedef enum logic [1:0] {BRIGHT, FADE_OUT, DARK, FADE_IN} fade_state_t;

   logic [COL_W-1:0] mem [NUM_BANKS][2**IDX_W];

   logic             wr_ok, rd_ok;
   logic [COL_W-1:0] rd_raw;
   logic             rd_key;
   logic             s1_valid, s1_key;
   logic [COL_W-1:0] s1_color;
   logic [COL_W-1:0] scaled;

   fade_state_t      state, state_n;
   logic [4:0]       level_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             done_n;

   assign wr_ok = int'(wr_bank) < NUM_BANKS;
   assign rd_ok = int'(rd_bank) < NUM_BANKS;

   // Palette contents deliberately survive reset.
   always_ff @(posedge Clk) begin
      if (wr_en && wr_ok)
         mem[wr_bank][wr_idx] <= wr_data;
   end

   always_comb begin
      rd_raw = '0;
      if (rd_ok) begin
         if (wr_en && (wr_bank == rd_bank) && (wr_idx == rd_idx))
            rd_raw = wr_data;
         else
            rd_raw = mem[rd_bank][rd_idx];
      end
      rd_key = rd_ok && (rd_raw == KEY_COLOR);
   end

   always_comb begin
      scaled = '0;
      for (int c = 0; c < 3; c++) begin
         scaled[c*CH_W +: CH_W] = CH_W'(({5'b0, s1_color[c*CH_W +: CH_W]} *
                                          {{CH_W{1'b0}}, fade_level}) >> 4);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid  <= 1'b0;
         s1_color  <= '0;
         s1_key    <= 1'b0;
         out_valid <= 1'b0;
         out_color <= '0;
         out_key   <= 1'b0;
      end else begin
         s1_valid  <= rd_valid;
         s1_color  <= rd_raw;
         s1_key    <= rd_key;
         out_valid <= s1_valid;
         out_color <= scaled;
         out_key   <= s1_key;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= BRIGHT;
         fade_level <= 5'd16;
         cnt        <= '0;
         fade_done  <= 1'b0;
      end else begin
         state      <= state_n;
         fade_level <= level_n;
         cnt        <= cnt_n;
         fade_done  <= done_n;
      end
   end

   // A frame_tick arriving with fade_start is ignored because only the fading states count ticks.
   always_comb begin
      state_n = state;
      level_n = fade_level;
      cnt_n   = cnt;
      done_n  = 1'b0;
      case (state)
         BRIGHT: begin
            if (fade_start && !fade_dir) begin
               state_n = FADE_OUT;
               cnt_n   = '0;
            end
         end
         DARK: begin
            if (fade_start && fade_dir) begin
               state_n = FADE_IN;
               cnt_n   = '0;
            end
         end
         FADE_OUT: begin
            if (frame_tick) begin
               if (cnt == CNT_W'(FRAMES_PER_STEP - 1)) begin
                  cnt_n   = '0;
                  level_n = fade_level - 5'd1;
                  if (fade_level == 5'd1) begin
                     state_n = DARK;
                     done_n  = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         FADE_IN: begin
            if (frame_tick) begin
               if (cnt == CNT_W'(FRAMES_PER_STEP - 1)) begin
                  cnt_n   = '0;
                  level_n = fade_level + 5'd1;
                  if (fade_level == 5'd15) begin
                     state_n = BRIGHT;
                     done_n  = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         default: state_n = BRIGHT;
      endcase
   end

   assign fade_busy = (state == FADE_OUT) || (state == FADE_IN);

endmodule

// File: tb/tb_palette_bank.sv
// tb/tb_palette_bank.sv - scoreboard bench for palette_bank lookups, keying and fades
module tb_palette_bank;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        wr_en, rd_valid;
   logic [1:0]  wr_bank, rd_bank;
   logic [6:0]  wr_idx, rd_idx;
   logic [23:0] wr_data;
   logic        out_valid, out_key;
   logic [23:0] out_color;
   logic        frame_tick, fade_start, fade_dir;
   logic        fade_busy, fade_done;
   logic [4:0]  fade_level;

   always #5 Clk = ~Clk;

   // Three banks so the 2-bit bank port can express an out-of-range bank (3).
   palette_bank #(
      .NUM_BANKS(3), .IDX_W(7), .CH_W(8),
      .KEY_COLOR(24'h0080ff), .FRAMES_PER_STEP(2)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_idx(rd_idx),
      .out_valid(out_valid), .out_color(out_color), .out_key(out_key),
      .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
      .fade_busy(fade_busy), .fade_done(fade_done), .fade_level(fade_level)
   );

   int          checks = 0;
   int          fails = 0;
   int          done_cnt = 0;
   int          run = 0;
   int          last_run = 0;
   logic [24:0] exp_q[$];
   logic [24:0] mon_e;
   logic [23:0] tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (fade_done) done_cnt++;
      if (out_valid) begin
         run++;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_output: got color %0h with empty scoreboard", out_color);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_color", {8'h0, out_color}, {8'h0, mon_e[24:1]});
            check("out_key", {31'h0, out_key}, {31'h0, mon_e[0]});
         end
      end else begin
         if (run > 0) last_run = run;
         run = 0;
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input logic [1:0] b, input logic [6:0] i, input logic [23:0] d);
      wr_en = 1'b1; wr_bank = b; wr_idx = i; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [1:0] b, input logic [6:0] i, input logic [23:0] c, input logic k);
      rd_valid = 1'b1; rd_bank = b; rd_idx = i;
      exp_q.push_back({c, k});
      step();
      rd_valid = 1'b0;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   initial begin
      tbl[0] = 24'h0080ff; tbl[1] = 24'h010203; tbl[2] = 24'hffffff; tbl[3] = 24'haabbcc;
      tbl[4] = 24'h000000; tbl[5] = 24'h123456; tbl[6] = 24'h0080fe; tbl[7] = 24'hff8010;
      Reset_n = 1'b0;
      wr_en = 0; rd_valid = 0; wr_bank = 0; rd_bank = 0; wr_idx = 0; rd_idx = 0; wr_data = 0;
      frame_tick = 0; fade_start = 0; fade_dir = 0;
      idle(2);
      check("rst_out_valid", {31'h0, out_valid}, 0);
      check("rst_out_color", {8'h0, out_color}, 0);
      check("rst_out_key", {31'h0, out_key}, 0);
      check("rst_level", {27'h0, fade_level}, 16);
      check("rst_busy", {31'h0, fade_busy}, 0);
      check("rst_done", {31'h0, fade_done}, 0);
      Reset_n = 1'b1;
      step();

      wr(1, 5, 24'h123456);
      rd_valid = 1'b1; rd_bank = 1; rd_idx = 5;
      exp_q.push_back({24'h123456, 1'b0});
      step();
      rd_valid = 1'b0;
      check("latency_stage1", {31'h0, out_valid}, 0);
      step();
      check("latency_stage2", {31'h0, out_valid}, 1);
      idle(2);

      wr(0, 0, 24'h0080ff);
      rd(0, 0, 24'h0080ff, 1'b1);
      wr_en = 1'b1; wr_bank = 0; wr_idx = 3; wr_data = 24'haabbcc;
      rd_valid = 1'b1; rd_bank = 0; rd_idx = 3;
      exp_q.push_back({24'haabbcc, 1'b0});
      step();
      wr_en = 1'b0; rd_valid = 1'b0;
      for (int i = 1; i < 8; i++) if (i != 3) wr(0, 7'(i), tbl[i]);
      for (int i = 0; i < 8; i++) begin
         rd_valid = 1'b1; rd_bank = 0; rd_idx = 7'(i);
         exp_q.push_back({tbl[i], i == 0});
         step();
      end
      rd_valid = 1'b0;
      idle(4);
      check("burst_run", last_run, 8);

      fade_dir = 1'b0; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      check("fade_out_busy", {31'h0, fade_busy}, 1);
      frames(4);
      check("level_after4", {27'h0, fade_level}, 14);
      rd(0, 7, 24'hdf700e, 1'b0);
      rd(0, 0, 24'h0070df, 1'b1);
      idle(3);
      frames(27);
      check("level_after31", {27'h0, fade_level}, 1);
      check("done_before_end", done_cnt, 0);
      frames(1);
      check("level_dark", {27'h0, fade_level}, 0);
      check("busy_dark", {31'h0, fade_busy}, 0);
      check("done_out_once", done_cnt, 1);
      rd(0, 0, 24'h000000, 1'b1);
      rd(1, 5, 24'h000000, 1'b0);
      idle(3);

      fade_dir = 1'b0; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      frames(4);
      check("dark_ignore_level", {27'h0, fade_level}, 0);
      check("dark_ignore_busy", {31'h0, fade_busy}, 0);
      check("dark_ignore_done", done_cnt, 1);

      fade_dir = 1'b1; fade_start = 1'b1; frame_tick = 1'b1;
      step();
      fade_start = 1'b0; frame_tick = 1'b0;
      step();
      check("fade_in_busy", {31'h0, fade_busy}, 1);
      frames(31);
      check("entry_tick_ignored", {27'h0, fade_level}, 15);
      frames(1);
      check("level_bright", {27'h0, fade_level}, 16);
      check("busy_bright", {31'h0, fade_busy}, 0);
      check("done_in_once", done_cnt, 2);
      rd(0, 2, 24'hffffff, 1'b0);
      idle(3);

      fade_dir = 1'b0; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
      frames(5);
      check("level_pre_reset", {27'h0, fade_level}, 14);
      #2 Reset_n = 1'b0;
      #1;
      check("async_rst_level", {27'h0, fade_level}, 16);
      check("async_rst_busy", {31'h0, fade_busy}, 0);
      @(posedge Clk);
      #1 Reset_n = 1'b1;
      step();
      rd(1, 5, 24'h123456, 1'b0);
      rd(0, 3, 24'haabbcc, 1'b0);
      idle(3);

      wr(3, 5, 24'habcdef);
      rd(3, 5, 24'h000000, 1'b0);
      rd(1, 5, 24'h123456, 1'b0);
      wr_en = 1'b1; wr_bank = 3; wr_idx = 0; wr_data = 24'h0080ff;
      rd_valid = 1'b1; rd_bank = 3; rd_idx = 0;
      exp_q.push_back({24'h000000, 1'b0});
      step();
      wr_en = 1'b0; rd_valid = 1'b0;
      rd(0, 0, 24'h0080ff, 1'b1);
      idle(4);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
